qeciphy_relink_sequencer: RTL



---
 rtl/qeciphy_relink_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/qeciphy_relink_sequencer.sv
// Arbitrates PHY reset/relink requests and runs one reset cycle at a time with timeout, retry and holdoff.
// Optional statistics outputs are enabled by defining QECIPHY_RELINK_STATS_EN.
//
// state      | meaning
// STARTUP    | power-on reset of the PHY, nothing serviced
// IDLE       | PHY out of reset, waiting for a pending request
// ASSERT     | o_phy_rst_n held low for RST_HOLD_CYCLES
// WAIT_DONE  | reset released, waiting for i_reset_done or timeout
// HOLDOFF    | post-reset quiet period, requests only accumulate
// FAILED     | retries exhausted, PHY parked in reset until i_fail_clear
module qeciphy_relink_sequencer #(
  parameter int NUM_REQ         = 3,
  parameter int RST_HOLD_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 65535,
  parameter int MAX_RETRY       = 3,
  parameter int HOLDOFF_CYCLES  = 256,
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1,
  localparam int SW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               axis_clk,
  input  logic               axis_rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  output logic [NUM_REQ-1:0] o_ack,
  output logic               o_phy_rst_n,
  input  logic               i_reset_done,
  output logic               o_busy,
  output logic [RW-1:0]      o_retry_cnt,
  output logic               o_fail,
  input  logic               i_fail_clear
`ifdef QECIPHY_RELINK_STATS_EN
  ,
  output logic [15:0]        o_reset_count,
  output logic [15:0]        o_fail_count,
  output logic [SW-1:0]      o_last_src
`endif
);

  localparam int TMAX_RH = (RST_HOLD_CYCLES > HOLDOFF_CYCLES) ? RST_HOLD_CYCLES : HOLDOFF_CYCLES;
  localparam int TMAX    = (TIMEOUT_CYCLES > TMAX_RH) ? TIMEOUT_CYCLES : TMAX_RH;
  localparam int TW      = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    ST_STARTUP,
    ST_IDLE,
    ST_ASSERT,
    ST_WAIT_DONE,
    ST_HOLDOFF,
    ST_FAILED
  } state_t;

  state_t             state;
  logic [TW-1:0]      timer;
  logic [NUM_REQ-1:0] pending;
  logic [NUM_REQ-1:0] serviced;
  logic [RW-1:0]      retry;

  assign o_retry_cnt = retry;

`ifdef QECIPHY_RELINK_STATS_EN
  function automatic logic [SW-1:0] lowest_set(input logic [NUM_REQ-1:0] v);
    lowest_set = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = SW'(i);
    end
  endfunction
`endif

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state       <= ST_STARTUP;
      timer       <= TW'(RST_HOLD_CYCLES - 1);
      pending     <= '0;
      serviced    <= '0;
      retry       <= '0;
      o_ack       <= '0;
      o_phy_rst_n <= 1'b0;
      o_busy      <= 1'b1;
      o_fail      <= 1'b0;
`ifdef QECIPHY_RELINK_STATS_EN
      o_reset_count <= '0;
      o_fail_count  <= '0;
      o_last_src    <= '0;
`endif
    end else begin
      o_ack   <= '0;
      pending <= pending | i_req;
      case (state)
        ST_STARTUP, ST_ASSERT: begin
          if (timer == '0) begin
            state       <= ST_WAIT_DONE;
            timer       <= TW'(TIMEOUT_CYCLES - 1);
            o_phy_rst_n <= 1'b1;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (i_reset_done) begin
            state <= ST_HOLDOFF;
            timer <= TW'(HOLDOFF_CYCLES - 1);
            o_ack <= serviced;
`ifdef QECIPHY_RELINK_STATS_EN
            if (o_reset_count != '1) o_reset_count <= o_reset_count + 16'd1;
`endif
          end else if (timer == '0) begin
            if (retry < RW'(MAX_RETRY)) begin
              retry       <= retry + RW'(1);
              state       <= ST_ASSERT;
              timer       <= TW'(RST_HOLD_CYCLES - 1);
              o_phy_rst_n <= 1'b0;
            end else begin
              // Unacknowledged requesters go back to pending so a later clear retries them.
              state       <= ST_FAILED;
              pending     <= pending | i_req | serviced;
              o_fail      <= 1'b1;
              o_busy      <= 1'b0;
              o_phy_rst_n <= 1'b0;
`ifdef QECIPHY_RELINK_STATS_EN
              if (o_fail_count != '1) o_fail_count <= o_fail_count + 16'd1;
`endif
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        ST_HOLDOFF: begin
          if (timer == '0) begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        ST_IDLE: begin
          if (pending != '0) begin
            serviced    <= pending;
            pending     <= i_req;
            retry       <= '0;
            state       <= ST_ASSERT;
            timer       <= TW'(RST_HOLD_CYCLES - 1);
            o_phy_rst_n <= 1'b0;
            o_busy      <= 1'b1;
`ifdef QECIPHY_RELINK_STATS_EN
            o_last_src  <= lowest_set(pending);
`endif
          end
        end
        ST_FAILED: begin
          if (i_fail_clear) begin
            state       <= ST_IDLE;
            o_fail      <= 1'b0;
            o_phy_rst_n <= 1'b1;
          end
        end
        default: begin
          state       <= ST_STARTUP;
          timer       <= TW'(RST_HOLD_CYCLES - 1);
          o_phy_rst_n <= 1'b0;
          o_busy      <= 1'b1;
        end
      endcase
    end
  end

endmodule
